prover_compute_v_encollect_cnt: RTL and testbench

Per-lane enable-pulse collector with credit counting. For each of `nParallel` lanes it waits until every participating input has delivered at least one enable pulse, then fires a one-cycle `en_out` pulse, gated by `en_master`. Each (lane, input) pair has a saturating counter, so pulses for the next round that arrive early or in the same cycle as a fire are kept, not dropped. It sits between the parallel per-input compute units and the next stage of the V-computation pipeline, and adds a runtime participation mask, flush and overflow reporting.

---
 rtl/prover_compute_v_encollect_cnt_if.sv | 24 ++
 rtl/prover_compute_v_encollect_cnt.sv | 90 +++++++++
 tb/tb_prover_compute_v_encollect_cnt.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/prover_compute_v_encollect_cnt_if.sv
// Handshake bundle between per-input compute units, the enable collector and the next V stage.
// en_in is unpacked over inputs: en_in[i][p] is the pulse from input i for lane p.
interface prover_compute_v_encollect_cnt_if #(
    parameter int ninputs   = 8,
    parameter int nParallel = 4
);
    logic                 en_master;
    logic [ninputs-1:0]   en_mask;
    logic [nParallel-1:0] en_in [ninputs];
    logic                 flush;
    logic [nParallel-1:0] en_out;
    logic [nParallel-1:0] pending;
    logic [nParallel-1:0] overflow;

    modport master (
        output en_master, en_mask, en_in, flush,
        input  en_out, pending, overflow
    );

    modport slave (
        input  en_master, en_mask, en_in, flush,
        output en_out, pending, overflow
    );
endinterface

// File: rtl/prover_compute_v_encollect_cnt.sv
// Per-lane enable collector: fires en_out once every participating input has a buffered credit.
// Credits are saturating per (lane, input) counters, so early pulses for the next round survive.
module prover_compute_v_encollect_cnt #(
    parameter int ninputs   = 8,
    parameter int nParallel = 4,
    parameter int depth     = 2
) (
    input  logic                          clk,
    input  logic                          rstb,
    prover_compute_v_encollect_cnt_if.slave bus
);
    localparam int cntBits = $clog2(depth + 1);
    localparam logic [cntBits-1:0] CNT_MAX = cntBits'(depth);

    logic [cntBits-1:0]   cnt_q [nParallel][ninputs];
    logic [cntBits-1:0]   cnt_d [nParallel][ninputs];
    logic [nParallel-1:0] ovf_q, ovf_d;
    logic [nParallel-1:0] sat;
    logic [nParallel-1:0] fire;
    logic [nParallel-1:0] pend;

    // Masked-off inputs count as satisfied even before their counter clears.
    always_comb begin
        sat = '1;
        for (int p = 0; p < nParallel; p++) begin
            for (int i = 0; i < ninputs; i++) begin
                if (bus.en_mask[i] && (cnt_q[p][i] == '0)) begin
                    sat[p] = 1'b0;
                end
            end
        end
        fire = {nParallel{bus.en_master & ~bus.flush & (|bus.en_mask)}} & sat;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.flush) begin
            for (int p = 0; p < nParallel; p++) begin
                for (int i = 0; i < ninputs; i++) begin
                    cnt_d[p][i] = '0;
                end
            end
            ovf_d = '0;
        end else begin
            for (int p = 0; p < nParallel; p++) begin
                for (int i = 0; i < ninputs; i++) begin
                    if (!bus.en_mask[i]) begin
                        cnt_d[p][i] = '0;
                    end else if (bus.en_in[i][p] && !fire[p]) begin
                        if (cnt_q[p][i] == CNT_MAX) begin
                            ovf_d[p] = 1'b1;
                        end else begin
                            cnt_d[p][i] = cnt_q[p][i] + cntBits'(1);
                        end
                    end else if (!bus.en_in[i][p] && fire[p]) begin
                        cnt_d[p][i] = cnt_q[p][i] - cntBits'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int p = 0; p < nParallel; p++) begin
            for (int i = 0; i < ninputs; i++) begin
                pend[p] = pend[p] | (cnt_q[p][i] != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int p = 0; p < nParallel; p++) begin
                for (int i = 0; i < ninputs; i++) begin
                    cnt_q[p][i] <= '0;
                end
            end
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.en_out   = fire;
    assign bus.pending  = pend;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_prover_compute_v_encollect_cnt.sv
// Bench for the enable collector: credit-count model checked every cycle, plus directed scenarios.
module tb_prover_compute_v_encollect_cnt;
    localparam int NI = 8;
    localparam int NP = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rstb;
    int   total = 0;
    int   bad = 0;

    int       mc [NP][NI];
    bit       movf [NP];
    logic [3:0] obs_out, obs_pend, obs_ovf;

    prover_compute_v_encollect_cnt_if #(.ninputs(NI), .nParallel(NP)) bus ();

    prover_compute_v_encollect_cnt #(.ninputs(NI), .nParallel(NP), .depth(DEPTH)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        for (int i = 0; i < NI; i++) bus.en_in[i] = '0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic [3:0] ef, ep, eo;
        int         nc [NP][NI];
        bit         no [NP];
        bit         all_ok;
        @(negedge clk);
        if (!rstb) begin
            for (int p = 0; p < NP; p++) begin
                movf[p] = 0;
                for (int i = 0; i < NI; i++) mc[p][i] = 0;
            end
        end
        for (int p = 0; p < NP; p++) begin
            all_ok = 1;
            ep[p] = 0;
            for (int i = 0; i < NI; i++) begin
                if (bus.en_mask[i] && mc[p][i] == 0) all_ok = 0;
                if (mc[p][i] != 0) ep[p] = 1;
            end
            ef[p] = bus.en_master && !bus.flush && (bus.en_mask != 0) && all_ok;
            eo[p] = movf[p];
        end
        obs_out = bus.en_out;
        obs_pend = bus.pending;
        obs_ovf = bus.overflow;
        check("en_out", 32'(obs_out), 32'(ef));
        check("pending", 32'(obs_pend), 32'(ep));
        check("overflow", 32'(obs_ovf), 32'(eo));
        for (int p = 0; p < NP; p++) begin
            no[p] = movf[p];
            for (int i = 0; i < NI; i++) begin
                nc[p][i] = 0;
                if (rstb && !bus.flush && bus.en_mask[i]) begin
                    nc[p][i] = mc[p][i] + int'(bus.en_in[i][p]) - int'(ef[p]);
                    if (nc[p][i] > DEPTH) begin
                        nc[p][i] = DEPTH;
                        no[p] = 1;
                    end
                end
            end
            if (!rstb || bus.flush) no[p] = 0;
        end
        @(posedge clk);
        #1;
        mc = nc;
        movf = no;
        clear_in();
    endtask

    initial begin
        rstb = 1'b0;
        bus.en_master = 1'b1;
        bus.en_mask = 8'hFF;
        bus.flush = 1'b0;
        clear_in();

        // Reset held: everything quiet.
        bus.en_in[0] = 4'hF;
        step();
        check("rst_en_out", 32'(obs_out), 32'h0);
        check("rst_pending", 32'(obs_pend), 32'h0);
        step();
        check("rst_overflow", 32'(obs_ovf), 32'h0);
        rstb = 1'b1;

        // Sequential pulses on lane 0 -> single fire on the ninth cycle.
        for (int k = 0; k < NI; k++) begin
            bus.en_in[k][0] = 1'b1;
            step();
            check("t1_no_early_fire", 32'(obs_out), 32'h0);
        end
        step();
        check("t1_fire_lane0", 32'(obs_out), 32'h1);
        step();
        check("t1_after_fire", 32'(obs_out), 32'h0);
        check("t1_pending_clear", 32'(obs_pend), 32'h0);

        // Two rounds buffered on lane 1 while master is low.
        bus.en_master = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NI; i++) bus.en_in[i][1] = 1'b1;
            step();
        end
        bus.en_master = 1'b1;
        step();
        check("t2_fire1", 32'(obs_out), 32'h2);
        step();
        check("t2_fire2", 32'(obs_out), 32'h2);
        step();
        check("t2_done", 32'(obs_out), 32'h0);
        check("t2_no_ovf", 32'(obs_ovf), 32'h0);

        // Saturation on lane 2, then flush.
        for (int k = 0; k < 3; k++) begin
            bus.en_in[3][2] = 1'b1;
            step();
        end
        step();
        check("t3_ovf_set", 32'(obs_ovf), 32'h4);
        step();
        check("t3_ovf_sticky", 32'(obs_ovf), 32'h4);
        bus.flush = 1'b1;
        bus.en_in[3][2] = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        check("t3_flush_ovf", 32'(obs_ovf), 32'h0);
        check("t3_flush_pend", 32'(obs_pend), 32'h0);

        // Fire coinciding with a fresh round keeps the new credits.
        bus.en_master = 1'b0;
        for (int i = 0; i < NI; i++) bus.en_in[i][0] = 1'b1;
        step();
        bus.en_master = 1'b1;
        for (int i = 0; i < NI; i++) bus.en_in[i][0] = 1'b1;
        step();
        check("t4_fire_a", 32'(obs_out), 32'h1);
        step();
        check("t4_fire_b", 32'(obs_out), 32'h1);
        check("t4_pending_b", 32'(obs_pend), 32'h1);
        step();
        check("t4_quiet", 32'(obs_out), 32'h0);

        // Partial mask on lane 3; masked inputs ignored.
        bus.en_mask = 8'h0F;
        for (int i = 4; i < NI; i++) bus.en_in[i][3] = 1'b1;
        step();
        step();
        check("t5_masked_pend", 32'(obs_pend), 32'h0);
        for (int i = 0; i < 4; i++) bus.en_in[i][3] = 1'b1;
        step();
        step();
        check("t5_fire_lane3", 32'(obs_out), 32'h8);
        bus.en_mask = 8'h00;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NI; i++) bus.en_in[i] = 4'hF;
            step();
            check("t5_zero_mask", 32'(obs_out), 32'h0);
        end

        // Reset mid-round loses partial credits.
        bus.en_mask = 8'hFF;
        for (int i = 0; i < 7; i++) bus.en_in[i][0] = 1'b1;
        step();
        step();
        check("t6_partial_pend", 32'(obs_pend), 32'h1);
        rstb = 1'b0;
        step();
        check("t6_rst_pend", 32'(obs_pend), 32'h0);
        check("t6_rst_out", 32'(obs_out), 32'h0);
        rstb = 1'b1;
        bus.en_in[7][0] = 1'b1;
        step();
        step();
        check("t6_no_fire", 32'(obs_out), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) bus.en_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            bus.en_master = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < NI; i++)
                for (int p = 0; p < NP; p++)
                    bus.en_in[i][p] = ($urandom_range(0, 2) == 0);
            rstb = ($urandom_range(0, 599) != 0);
            step();
        end
        rstb = 1'b1;
        bus.flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
